// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional flag outputs are enabled with `define SHIFTER_FLAGS_EN.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRA = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } shift_mode_e;

  // Levels packed into every stage but the last, which takes whatever remains.
  function automatic int levels_per_stage(input int shamt_w, input int latency);
    return (shamt_w + latency - 1) / latency;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the log shifter: shifts by DIST when enabled.
// The carry port exists only when SHIFTER_FLAGS_EN is defined.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  shift_mode_e      mode,
  input  logic             fill,
`ifdef SHIFTER_FLAGS_EN
  output logic             carry,
`endif
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shifted;

  // NOTE: every path assigns 'shifted' (default included), so no latch is inferred.
  always_comb begin
    unique case (mode)
      SH_SLL:  shifted = data << DIST;
      SH_SRL:  shifted = data >> DIST;
      SH_SRA:  shifted = {{DIST{fill}}, data[WIDTH-1:DIST]};
      SH_ROR:  shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
      default: shifted = data;
    endcase
  end

  assign result = en ? shifted : data;

`ifdef SHIFTER_FLAGS_EN
  // The last bit to leave: top bit for SLL, bit DIST-1 otherwise (for ROR it lands in the MSB).
  assign carry = en & ((mode == SH_SLL) ? data[WIDTH-DIST] : data[DIST-1]);
`endif

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR) with valid/ready and a tag sideband.
// Define SHIFTER_FLAGS_EN to add the out_zero / out_carry result flags.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int LATENCY = 2,
  parameter  int TAG_W   = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
`ifdef SHIFTER_FLAGS_EN
  output logic               out_zero,
  output logic               out_carry,
`endif
  output logic [TAG_W-1:0]   out_tag
);

  localparam int LPS = levels_per_stage(SHAMT_W, LATENCY);

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    shift_mode_e        mode;
    logic               fill;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t           head;
  stage_t           stage_in  [LATENCY];
  stage_t           stage_out [LATENCY];
  stage_t           stage_q   [LATENCY];
  logic [WIDTH-1:0] lvl_data  [SHAMT_W];
  logic [WIDTH-1:0] lvl_res   [SHAMT_W];
  logic             adv;

`ifdef SHIFTER_FLAGS_EN
  logic lvl_cin   [SHAMT_W];
  logic lvl_craw  [SHAMT_W];
  logic lvl_cout  [SHAMT_W];
  logic carry_in  [LATENCY];
  logic carry_out [LATENCY];
  logic zero_out  [LATENCY];
  logic carry_q   [LATENCY];
  logic zero_q    [LATENCY];
`endif

  // Global stall: the whole pipe moves together, bubbles are not squeezed out.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // SRA fill is the original sign bit, captured once and carried with the op.
  assign head = '{valid: in_valid, data: in_data, shamt: in_shamt,
                  mode: shift_mode_e'(in_mode), fill: in_data[WIDTH-1], tag: in_tag};

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int LO = s * LPS;
    localparam int HI = (LO + LPS < SHAMT_W) ? LO + LPS : SHAMT_W;

    if (s == 0) begin : g_head
      assign stage_in[s] = head;
`ifdef SHIFTER_FLAGS_EN
      assign carry_in[s] = 1'b0;
`endif
    end else begin : g_link
      assign stage_in[s] = stage_q[s-1];
`ifdef SHIFTER_FLAGS_EN
      assign carry_in[s] = carry_q[s-1];
`endif
    end

    if (LO < SHAMT_W) begin : g_work
      assign stage_out[s] = '{valid: stage_in[s].valid, data: lvl_res[HI-1],
                              shamt: stage_in[s].shamt, mode: stage_in[s].mode,
                              fill: stage_in[s].fill, tag: stage_in[s].tag};
`ifdef SHIFTER_FLAGS_EN
      assign carry_out[s] = lvl_cout[HI-1];
`endif
    end else begin : g_pass
      assign stage_out[s] = stage_in[s];
`ifdef SHIFTER_FLAGS_EN
      assign carry_out[s] = carry_in[s];
`endif
    end

`ifdef SHIFTER_FLAGS_EN
    assign zero_out[s] = (stage_out[s].data == '0);
`endif
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int S = k / LPS;

    if (k % LPS == 0) begin : g_first
      assign lvl_data[k] = stage_in[S].data;
`ifdef SHIFTER_FLAGS_EN
      assign lvl_cin[k]  = carry_in[S];
`endif
    end else begin : g_chain
      assign lvl_data[k] = lvl_res[k-1];
`ifdef SHIFTER_FLAGS_EN
      assign lvl_cin[k]  = lvl_cout[k-1];
`endif
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .data   (lvl_data[k]),
      .en     (stage_in[S].shamt[k]),
      .mode   (stage_in[S].mode),
      .fill   (stage_in[S].fill),
`ifdef SHIFTER_FLAGS_EN
      .carry  (lvl_craw[k]),
`endif
      .result (lvl_res[k])
    );

`ifdef SHIFTER_FLAGS_EN
    // A disabled level shifts nothing out, so the earlier carry survives.
    assign lvl_cout[k] = stage_in[S].shamt[k] ? lvl_craw[k] : lvl_cin[k];
`endif
  end

  // NOTE: datapath registers are reset as well, because out_data/out_tag must read 0 after reset.
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) stage_q[s] <= '0;
    end else if (adv) begin
      for (int s = 0; s < LATENCY; s++) stage_q[s] <= stage_out[s];
    end
  end

`ifdef SHIFTER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        carry_q[s] <= 1'b0;
        zero_q[s]  <= 1'b0;
      end
    end else if (adv) begin
      for (int s = 0; s < LATENCY; s++) begin
        carry_q[s] <= carry_out[s];
        zero_q[s]  <= zero_out[s];
      end
    end
  end

  assign out_zero  = zero_q[LATENCY-1];
  assign out_carry = carry_q[LATENCY-1];
`endif

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_data  = stage_q[LATENCY-1].data;
  assign out_tag   = stage_q[LATENCY-1].tag;

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=16); override LATENCY to rerun at 1..4.
// Flag checks are compiled in when SHIFTER_FLAGS_EN is defined.
module tb_pipe_shifter;
  import shifter_pkg::*;

  parameter  int LATENCY = 2;
  localparam int WIDTH   = 16;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [3:0]       in_shamt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef SHIFTER_FLAGS_EN
  logic             out_zero, out_carry;
`endif

  pipe_shifter #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SHIFTER_FLAGS_EN
    .out_zero  (out_zero),
    .out_carry (out_carry),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             carry;
    logic             zero;
    int               acc_cyc;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;  // 0: always ready, 1: 1,0,0,0 pattern, 2: never ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ready();
    case (ready_mode)
      1:       out_ready = (cyc % 4 == 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  // Drives one op after the next edge and holds it until accepted; returns on the accept cycle.
  task automatic issue(input logic [1:0] mode, input logic [15:0] data, input logic [3:0] shamt,
                       input logic [3:0] tag, input logic [15:0] exp_data, input logic exp_carry);
    exp_t e;
    int   waited = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = mode; in_data = data; in_shamt = shamt; in_tag = tag;
    set_ready();
    @(negedge clk);
    while (!in_ready && waited < 64) begin
      @(posedge clk); #1; set_ready();
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: tag %0d not accepted after %0d cycles", tag, waited);
    end else begin
      e.data = exp_data; e.tag = tag; e.carry = exp_carry; e.zero = (exp_data == 16'h0);
      e.acc_cyc = cyc; e.chk_lat = (ready_mode == 0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    @(posedge clk); #1; in_valid = 1'b0; set_ready();
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; set_ready();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: pops on every output handshake and watches the stall boundary.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic [TAG_W-1:0] prev_tag;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_data", {16'h0, out_data}, {16'h0, e.data});
          check("out_tag", {28'h0, out_tag}, {28'h0, e.tag});
`ifdef SHIFTER_FLAGS_EN
          check("out_carry", {31'h0, out_carry}, {31'h0, e.carry});
          check("out_zero", {31'h0, out_zero}, {31'h0, e.zero});
`endif
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, LATENCY);
        end
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {31'h0, in_ready}, 32'h0);
        if (prev_stall) begin
          check("stall_data_stable", {16'h0, out_data}, {16'h0, prev_data});
          check("stall_tag_stable", {28'h0, out_tag}, {28'h0, prev_tag});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_out_data", {16'h0, out_data}, 32'h0);
    check("reset_out_tag", {28'h0, out_tag}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef SHIFTER_FLAGS_EN
    check("reset_out_zero", {31'h0, out_zero}, 32'h0);
    check("reset_out_carry", {31'h0, out_carry}, 32'h0);
`endif

    // Directed single ops, always ready.
    issue(SH_SLL, 16'h8001, 4'd1,  4'd3,  16'h0002, 1'b1);
    issue(SH_SRA, 16'h8000, 4'd15, 4'd4,  16'hFFFF, 1'b0);
    issue(SH_SRL, 16'h8000, 4'd15, 4'd5,  16'h0001, 1'b0);
    issue(SH_SRA, 16'h7FF0, 4'd4,  4'd6,  16'h07FF, 1'b0);
    issue(SH_ROR, 16'h1234, 4'd4,  4'd7,  16'h4123, 1'b0);
    issue(SH_SLL, 16'hA5A5, 4'd0,  4'd8,  16'hA5A5, 1'b0);
    issue(SH_SRA, 16'hA5A5, 4'd0,  4'd9,  16'hA5A5, 1'b0);
    issue(SH_ROR, 16'hA5A5, 4'd0,  4'd10, 16'hA5A5, 1'b0);
    issue(SH_SRL, 16'hA5A5, 4'd0,  4'd11, 16'hA5A5, 1'b0);
    issue(SH_SLL, 16'h0001, 4'd15, 4'd12, 16'h8000, 1'b0);
    issue(SH_SLL, 16'h8000, 4'd1,  4'd13, 16'h0000, 1'b1);
    wait_drain();

    // Back-to-back stream with the consumer ready only one cycle in four.
    ready_mode = 1;
    issue(SH_SRL, 16'hF00F, 4'd4,  4'd0, 16'h0F00, 1'b1);
    issue(SH_ROR, 16'h0001, 4'd1,  4'd1, 16'h8000, 1'b1);
    issue(SH_SRA, 16'hC000, 4'd2,  4'd2, 16'hF000, 1'b0);
    issue(SH_SLL, 16'h00FF, 4'd8,  4'd3, 16'hFF00, 1'b0);
    issue(SH_ROR, 16'hABCD, 4'd8,  4'd4, 16'hCDAB, 1'b1);
    issue(SH_SRL, 16'hFFFF, 4'd15, 4'd5, 16'h0001, 1'b1);
    issue(SH_SLL, 16'h1234, 4'd12, 4'd6, 16'h4000, 1'b1);
    issue(SH_SRA, 16'h8421, 4'd3,  4'd7, 16'hF084, 1'b0);
    wait_drain();

    // Fill the pipe while stalled, then reset mid-flight.
    ready_mode = 2;
    for (int i = 0; i < LATENCY; i++) issue(SH_SLL, 16'h00F0, 4'd2, 4'(i + 1), 16'h03C0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    ready_mode = 0; set_ready();
    @(negedge clk);
    check("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    issue(SH_SRL, 16'h0F0F, 4'd4, 4'd9, 16'h00F0, 1'b1);
    wait_drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
